// File: rtl/calc2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc2_pkg
// Description : Shared types, command/response codes and small helpers for
//               the calc2 port issuer slice.
// Revision    : 1.0 - initial release
// ============================================================================
package calc2_pkg;

    typedef logic [0:1]  tag_t;
    typedef logic [0:31] data_t;
    typedef logic [0:3]  cmd_t;
    typedef logic [0:1]  resp_t;

    localparam int c_NUM_TAGS = 4;

    localparam cmd_t CMD_NOP = 4'd0;
    localparam cmd_t CMD_ADD = 4'd1;
    localparam cmd_t CMD_SUB = 4'd2;
    localparam cmd_t CMD_SHL = 4'd5;
    localparam cmd_t CMD_SHR = 4'd6;

    localparam resp_t RESP_NONE    = 2'd0;
    localparam resp_t RESP_OK      = 2'd1;
    localparam resp_t RESP_ERR     = 2'd2;
    localparam resp_t RESP_TIMEOUT = 2'd3;

    function automatic logic [0:2] popcount4(input logic [0:c_NUM_TAGS-1] v);
        logic [0:2] n;
        n = '0;
        for (int i = 0; i < c_NUM_TAGS; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

    // Scans downward so the last hit written is the lowest-numbered free tag.
    function automatic tag_t lowest_free(input logic [0:c_NUM_TAGS-1] busy);
        tag_t t;
        t = '0;
        for (int i = c_NUM_TAGS - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                t = tag_t'(i);
            end
        end
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/calc2_tag_tracker.sv
`default_nettype none
// ============================================================================
// Module      : calc2_tag_tracker
// Description : Busy bitmap, lowest-free allocator, per-tag age counters with
//               timeout arbitration, and registered outstanding count.
// Revision    : 1.0 - initial release
// ============================================================================
module calc2_tag_tracker
    import calc2_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_alloc,
    input  logic       i_rsp_valid,
    input  tag_t       i_rsp_tag,
    output logic       o_any_free,
    output tag_t       o_alloc_tag,
    output logic       o_rsp_hit,
    output logic       o_to_valid,
    output tag_t       o_to_tag,
    output logic [0:2] o_outstanding
);

    localparam logic [0:CNT_W-1] c_AGE_MAX = CNT_W'(TIMEOUT);

    logic [0:c_NUM_TAGS-1] r_busy;
    logic [0:CNT_W-1]      r_age [c_NUM_TAGS];
    logic [0:2]            r_outstanding;
    logic [0:c_NUM_TAGS-1] w_pending;
    logic [0:c_NUM_TAGS-1] w_busy_next;

    assign o_any_free    = ~&r_busy;
    assign o_alloc_tag   = lowest_free(r_busy);
    assign o_rsp_hit     = i_rsp_valid && r_busy[i_rsp_tag];
    assign o_outstanding = r_outstanding;

    always_comb begin
        w_pending = '0;
        for (int t = 0; t < c_NUM_TAGS; t++) begin
            w_pending[t] = r_busy[t] && (r_age[t] == c_AGE_MAX);
        end
    end

    // A real response owns the host slot; pending timeouts hold and retry.
    always_comb begin
        o_to_tag = '0;
        for (int t = c_NUM_TAGS - 1; t >= 0; t--) begin
            if (w_pending[t]) begin
                o_to_tag = tag_t'(t);
            end
        end
    end

    assign o_to_valid = (|w_pending) && !o_rsp_hit;

    always_comb begin
        w_busy_next = r_busy;
        if (i_alloc) begin
            w_busy_next[o_alloc_tag] = 1'b1;
        end
        if (o_rsp_hit) begin
            w_busy_next[i_rsp_tag] = 1'b0;
        end
        if (o_to_valid) begin
            w_busy_next[o_to_tag] = 1'b0;
        end
    end

    // Age is zeroed on allocation so it reads 0 during the command cycle and
    // counts every cycle after it, saturating at TIMEOUT.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy        <= '0;
            r_outstanding <= '0;
            for (int t = 0; t < c_NUM_TAGS; t++) begin
                r_age[t] <= '0;
            end
        end else begin
            r_busy        <= w_busy_next;
            r_outstanding <= popcount4(w_busy_next);
            for (int t = 0; t < c_NUM_TAGS; t++) begin
                if (i_alloc && (o_alloc_tag == tag_t'(t))) begin
                    r_age[t] <= '0;
                end else if (r_busy[t] && (r_age[t] != c_AGE_MAX)) begin
                    r_age[t] <= r_age[t] + CNT_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/calc2_port_issuer.sv
`default_nettype none
// ============================================================================
// Module      : calc2_port_issuer
// Description : Host-facing issuer for one calc2 request port: two-cycle
//               command/operand sequencing plus tagged response return.
// Revision    : 1.0 - initial release
// ============================================================================
module calc2_port_issuer
    import calc2_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        host_req_valid,
    output logic        host_req_ready,
    input  logic [0:3]  host_req_cmd,
    input  logic [0:31] host_req_op1,
    input  logic [0:31] host_req_op2,
    output logic [0:3]  req_cmd_out,
    output logic [0:31] req_data_out,
    output logic [0:1]  req_tag_out,
    input  logic [0:1]  dut_resp_in,
    input  logic [0:31] dut_data_in,
    input  logic [0:1]  dut_tag_in,
    output logic        host_rsp_valid,
    output logic [0:1]  host_rsp_resp,
    output logic [0:31] host_rsp_data,
    output logic [0:1]  host_rsp_tag,
    output logic [0:2]  outstanding,
    output logic        stray_resp_err
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CMD  = 2'd1;
    localparam logic [1:0] c_ST_OPND = 2'd2;

    logic [1:0] r_state;
    data_t      r_op2;
    cmd_t       r_req_cmd;
    data_t      r_req_data;
    tag_t       r_req_tag;
    logic       r_rsp_valid;
    resp_t      r_rsp_resp;
    data_t      r_rsp_data;
    tag_t       r_rsp_tag;
    logic       r_stray;

    logic w_accept;
    logic w_alloc;
    logic w_any_free;
    tag_t w_alloc_tag;
    logic w_rsp_valid;
    logic w_rsp_hit;
    logic w_to_valid;
    tag_t w_to_tag;

    assign host_req_ready = ((r_state == c_ST_IDLE) || (r_state == c_ST_OPND))
                            && w_any_free && !reset;
    assign w_accept    = host_req_valid && host_req_ready;
    assign w_alloc     = w_accept && (host_req_cmd != CMD_NOP);
    assign w_rsp_valid = (dut_resp_in != RESP_NONE);

    calc2_tag_tracker #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_tracker (
        .clk           (clk),
        .reset         (reset),
        .i_alloc       (w_alloc),
        .i_rsp_valid   (w_rsp_valid),
        .i_rsp_tag     (dut_tag_in),
        .o_any_free    (w_any_free),
        .o_alloc_tag   (w_alloc_tag),
        .o_rsp_hit     (w_rsp_hit),
        .o_to_valid    (w_to_valid),
        .o_to_tag      (w_to_tag),
        .o_outstanding (outstanding)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_op2       <= '0;
            r_req_cmd   <= '0;
            r_req_data  <= '0;
            r_req_tag   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_resp  <= '0;
            r_rsp_data  <= '0;
            r_rsp_tag   <= '0;
            r_stray     <= 1'b0;
        end else begin
            case (r_state)
                c_ST_CMD: begin
                    r_state    <= c_ST_OPND;
                    r_req_cmd  <= CMD_NOP;
                    r_req_data <= r_op2;
                    r_req_tag  <= '0;
                end
                default: begin
                    // Only op2 needs holding; cmd/op1/tag go straight out.
                    if (w_alloc) begin
                        r_state    <= c_ST_CMD;
                        r_req_cmd  <= host_req_cmd;
                        r_req_data <= host_req_op1;
                        r_req_tag  <= w_alloc_tag;
                        r_op2      <= host_req_op2;
                    end else begin
                        r_state    <= c_ST_IDLE;
                        r_req_cmd  <= '0;
                        r_req_data <= '0;
                        r_req_tag  <= '0;
                    end
                end
            endcase

            r_rsp_valid <= w_rsp_hit || w_to_valid;
            r_stray     <= w_rsp_valid && !w_rsp_hit;
            if (w_rsp_hit) begin
                r_rsp_resp <= dut_resp_in;
                r_rsp_data <= dut_data_in;
                r_rsp_tag  <= dut_tag_in;
            end else if (w_to_valid) begin
                r_rsp_resp <= RESP_TIMEOUT;
                r_rsp_data <= '0;
                r_rsp_tag  <= w_to_tag;
            end else begin
                r_rsp_resp <= '0;
                r_rsp_data <= '0;
                r_rsp_tag  <= '0;
            end
        end
    end

    assign req_cmd_out    = r_req_cmd;
    assign req_data_out   = r_req_data;
    assign req_tag_out    = r_req_tag;
    assign host_rsp_valid = r_rsp_valid;
    assign host_rsp_resp  = r_rsp_resp;
    assign host_rsp_data  = r_rsp_data;
    assign host_rsp_tag   = r_rsp_tag;
    assign stray_resp_err = r_stray;

endmodule
`default_nettype wire

// File: tb/tb_calc2_port_issuer.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc2_port_issuer
// Description : Directed vector bench for calc2_port_issuer (default timeout)
//               plus short-timeout sequences on a second instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc2_port_issuer;
    import calc2_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        v, rdy, hv, stray;
    logic [0:3]  cmd, rc;
    logic [0:31] op1, op2, dd, rd, hd;
    logic [0:1]  dr, dt, rt, hr, ht;
    logic [0:2]  outst;

    logic        v8, rdy8, hv8, stray8;
    logic [0:3]  cmd8, rc8;
    logic [0:31] op1_8, op2_8, dd8, rd8, hd8;
    logic [0:1]  dr8, dt8, rt8, hr8, ht8;
    logic [0:2]  outst8;

    int checks = 0;
    int errors = 0;

    calc2_port_issuer #(.TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .host_req_valid(v), .host_req_ready(rdy), .host_req_cmd(cmd),
        .host_req_op1(op1), .host_req_op2(op2),
        .req_cmd_out(rc), .req_data_out(rd), .req_tag_out(rt),
        .dut_resp_in(dr), .dut_data_in(dd), .dut_tag_in(dt),
        .host_rsp_valid(hv), .host_rsp_resp(hr), .host_rsp_data(hd), .host_rsp_tag(ht),
        .outstanding(outst), .stray_resp_err(stray)
    );

    calc2_port_issuer #(.TIMEOUT(8)) dut8 (
        .clk(clk), .reset(reset),
        .host_req_valid(v8), .host_req_ready(rdy8), .host_req_cmd(cmd8),
        .host_req_op1(op1_8), .host_req_op2(op2_8),
        .req_cmd_out(rc8), .req_data_out(rd8), .req_tag_out(rt8),
        .dut_resp_in(dr8), .dut_data_in(dd8), .dut_tag_in(dt8),
        .host_rsp_valid(hv8), .host_rsp_resp(hr8), .host_rsp_data(hd8), .host_rsp_tag(ht8),
        .outstanding(outst8), .stray_resp_err(stray8)
    );

    typedef struct {
        logic        rst;
        logic        v;
        logic [0:3]  cmd;
        logic [0:31] op1, op2;
        logic [0:1]  dr;
        logic [0:31] dd;
        logic [0:1]  dt;
        logic        rdy;
        logic [0:3]  rc;
        logic [0:31] rd;
        logic [0:1]  rt;
        logic        hv;
        logic [0:1]  hr;
        logic [0:31] hd;
        logic [0:1]  ht;
        logic [0:2]  out;
        logic        stray;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic iv, input logic [0:3] icmd,
                       input logic [0:31] iop1, input logic [0:31] iop2,
                       input logic [0:1] idr, input logic [0:31] idd, input logic [0:1] idt,
                       input logic erdy, input logic [0:3] erc, input logic [0:31] erd,
                       input logic [0:1] ert, input logic ehv, input logic [0:1] ehr,
                       input logic [0:31] ehd, input logic [0:1] eht,
                       input logic [0:2] eout, input logic estray);
        vec_t e;
        e.rst = rst; e.v = iv; e.cmd = icmd; e.op1 = iop1; e.op2 = iop2;
        e.dr = idr; e.dd = idd; e.dt = idt;
        e.rdy = erdy; e.rc = erc; e.rd = erd; e.rt = ert;
        e.hv = ehv; e.hr = ehr; e.hd = ehd; e.ht = eht;
        e.out = eout; e.stray = estray;
        vecs.push_back(e);
    endtask

    task automatic check_vec(input int idx, input vec_t e);
        checks++;
        if (rdy !== e.rdy || rc !== e.rc || rd !== e.rd || rt !== e.rt ||
            hv !== e.hv || hr !== e.hr || hd !== e.hd || ht !== e.ht ||
            outst !== e.out || stray !== e.stray) begin
            errors++;
            $display("FAIL vec%0d: got rdy=%0b req=%0d/%0d/%0d rsp=%0b/%0d/%0d/%0d out=%0d stray=%0b want rdy=%0b req=%0d/%0d/%0d rsp=%0b/%0d/%0d/%0d out=%0d stray=%0b",
                     idx, rdy, rc, rd, rt, hv, hr, hd, ht, outst, stray,
                     e.rdy, e.rc, e.rd, e.rt, e.hv, e.hr, e.hd, e.ht, e.out, e.stray);
        end
    endtask

    task automatic chk(input string name, input logic [0:31] act, input logic [0:31] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        v = 0; cmd = '0; op1 = '0; op2 = '0; dr = '0; dd = '0; dt = '0;
        v8 = 0; cmd8 = '0; op1_8 = '0; op2_8 = '0; dr8 = '0; dd8 = '0; dt8 = '0;

        //   rst v  cmd      op1 op2 dr         dd  dt | rdy rc       rd  rt hv hr        hd  ht out stray
        // single ADD and its response
        add(0, 0, CMD_NOP, 0,  0,  RESP_NONE, 0,  0,   1,  CMD_NOP, 0,  0, 0, RESP_NONE, 0,  0, 0, 0);
        add(0, 1, CMD_ADD, 5,  7,  RESP_NONE, 0,  0,   1,  CMD_NOP, 0,  0, 0, RESP_NONE, 0,  0, 0, 0);
        add(0, 0, CMD_NOP, 0,  0,  RESP_NONE, 0,  0,   0,  CMD_ADD, 5,  0, 0, RESP_NONE, 0,  0, 1, 0);
        add(0, 0, CMD_NOP, 0,  0,  RESP_NONE, 0,  0,   1,  CMD_NOP, 7,  0, 0, RESP_NONE, 0,  0, 1, 0);
        add(0, 0, CMD_NOP, 0,  0,  RESP_NONE, 0,  0,   1,  CMD_NOP, 0,  0, 0, RESP_NONE, 0,  0, 1, 0);
        add(0, 0, CMD_NOP, 0,  0,  RESP_NONE, 0,  0,   1,  CMD_NOP, 0,  0, 0, RESP_NONE, 0,  0, 1, 0);
        add(0, 0, CMD_NOP, 0,  0,  RESP_NONE, 0,  0,   1,  CMD_NOP, 0,  0, 0, RESP_NONE, 0,  0, 1, 0);
        add(0, 0, CMD_NOP, 0,  0,  RESP_OK,   12, 0,   1,  CMD_NOP, 0,  0, 0, RESP_NONE, 0,  0, 1, 0);
        add(0, 0, CMD_NOP, 0,  0,  RESP_NONE, 0,  0,   1,  CMD_NOP, 0,  0, 1, RESP_OK,   12, 0, 0, 0);
        add(0, 0, CMD_NOP, 0,  0,  RESP_NONE, 0,  0,   1,  CMD_NOP, 0,  0, 0, RESP_NONE, 0,  0, 0, 0);
        // five back-to-back operations, table fills, tag 2 freed and reused
        add(0, 1, CMD_SUB, 10, 3,  RESP_NONE, 0,  0,   1,  CMD_NOP, 0,  0, 0, RESP_NONE, 0,  0, 0, 0);
        add(0, 1, CMD_SHL, 11, 1,  RESP_NONE, 0,  0,   0,  CMD_SUB, 10, 0, 0, RESP_NONE, 0,  0, 1, 0);
        add(0, 1, CMD_SHL, 11, 1,  RESP_NONE, 0,  0,   1,  CMD_NOP, 3,  0, 0, RESP_NONE, 0,  0, 1, 0);
        add(0, 1, CMD_SHR, 12, 2,  RESP_NONE, 0,  0,   0,  CMD_SHL, 11, 1, 0, RESP_NONE, 0,  0, 2, 0);
        add(0, 1, CMD_SHR, 12, 2,  RESP_NONE, 0,  0,   1,  CMD_NOP, 1,  0, 0, RESP_NONE, 0,  0, 2, 0);
        add(0, 1, CMD_ADD, 13, 4,  RESP_NONE, 0,  0,   0,  CMD_SHR, 12, 2, 0, RESP_NONE, 0,  0, 3, 0);
        add(0, 1, CMD_ADD, 13, 4,  RESP_NONE, 0,  0,   1,  CMD_NOP, 2,  0, 0, RESP_NONE, 0,  0, 3, 0);
        add(0, 1, CMD_SUB, 14, 5,  RESP_NONE, 0,  0,   0,  CMD_ADD, 13, 3, 0, RESP_NONE, 0,  0, 4, 0);
        add(0, 1, CMD_SUB, 14, 5,  RESP_NONE, 0,  0,   0,  CMD_NOP, 4,  0, 0, RESP_NONE, 0,  0, 4, 0);
        add(0, 1, CMD_SUB, 14, 5,  RESP_OK,   99, 2,   0,  CMD_NOP, 0,  0, 0, RESP_NONE, 0,  0, 4, 0);
        add(0, 1, CMD_SUB, 14, 5,  RESP_NONE, 0,  0,   1,  CMD_NOP, 0,  0, 1, RESP_OK,   99, 2, 3, 0);
        add(0, 0, CMD_NOP, 0,  0,  RESP_NONE, 0,  0,   0,  CMD_SUB, 14, 2, 0, RESP_NONE, 0,  0, 4, 0);
        add(0, 0, CMD_NOP, 0,  0,  RESP_NONE, 0,  0,   0,  CMD_NOP, 5,  0, 0, RESP_NONE, 0,  0, 4, 0);
        add(0, 0, CMD_NOP, 0,  0,  RESP_NONE, 0,  0,   0,  CMD_NOP, 0,  0, 0, RESP_NONE, 0,  0, 4, 0);
        // out-of-order responses 3 then 0, then drain 1 and 2
        add(0, 0, CMD_NOP, 0,  0,  RESP_OK,   33, 3,   0,  CMD_NOP, 0,  0, 0, RESP_NONE, 0,  0, 4, 0);
        add(0, 0, CMD_NOP, 0,  0,  RESP_ERR,  44, 0,   1,  CMD_NOP, 0,  0, 1, RESP_OK,   33, 3, 3, 0);
        add(0, 0, CMD_NOP, 0,  0,  RESP_NONE, 0,  0,   1,  CMD_NOP, 0,  0, 1, RESP_ERR,  44, 0, 2, 0);
        add(0, 0, CMD_NOP, 0,  0,  RESP_OK,   1,  1,   1,  CMD_NOP, 0,  0, 0, RESP_NONE, 0,  0, 2, 0);
        add(0, 0, CMD_NOP, 0,  0,  RESP_OK,   2,  2,   1,  CMD_NOP, 0,  0, 1, RESP_OK,   1,  1, 1, 0);
        add(0, 0, CMD_NOP, 0,  0,  RESP_NONE, 0,  0,   1,  CMD_NOP, 0,  0, 1, RESP_OK,   2,  2, 0, 0);
        // stray response on tag 1 with only tag 0 busy, then a NOP accept
        add(0, 1, CMD_ADD, 7,  8,  RESP_NONE, 0,  0,   1,  CMD_NOP, 0,  0, 0, RESP_NONE, 0,  0, 0, 0);
        add(0, 0, CMD_NOP, 0,  0,  RESP_NONE, 0,  0,   0,  CMD_ADD, 7,  0, 0, RESP_NONE, 0,  0, 1, 0);
        add(0, 0, CMD_NOP, 0,  0,  RESP_NONE, 0,  0,   1,  CMD_NOP, 8,  0, 0, RESP_NONE, 0,  0, 1, 0);
        add(0, 0, CMD_NOP, 0,  0,  RESP_OK,   5,  1,   1,  CMD_NOP, 0,  0, 0, RESP_NONE, 0,  0, 1, 0);
        add(0, 0, CMD_NOP, 0,  0,  RESP_NONE, 0,  0,   1,  CMD_NOP, 0,  0, 0, RESP_NONE, 0,  0, 1, 1);
        add(0, 1, CMD_NOP, 9,  9,  RESP_NONE, 0,  0,   1,  CMD_NOP, 0,  0, 0, RESP_NONE, 0,  0, 1, 0);
        // second tag busy, reset in OPND with a response that must be ignored
        add(0, 1, CMD_ADD, 20, 21, RESP_NONE, 0,  0,   1,  CMD_NOP, 0,  0, 0, RESP_NONE, 0,  0, 1, 0);
        add(0, 0, CMD_NOP, 0,  0,  RESP_NONE, 0,  0,   0,  CMD_ADD, 20, 1, 0, RESP_NONE, 0,  0, 2, 0);
        add(1, 0, CMD_NOP, 0,  0,  RESP_OK,   77, 0,   0,  CMD_NOP, 21, 0, 0, RESP_NONE, 0,  0, 2, 0);
        add(0, 0, CMD_NOP, 0,  0,  RESP_NONE, 0,  0,   1,  CMD_NOP, 0,  0, 0, RESP_NONE, 0,  0, 0, 0);
        add(0, 0, CMD_NOP, 0,  0,  RESP_OK,   3,  1,   1,  CMD_NOP, 0,  0, 0, RESP_NONE, 0,  0, 0, 0);
        add(0, 0, CMD_NOP, 0,  0,  RESP_NONE, 0,  0,   1,  CMD_NOP, 0,  0, 0, RESP_NONE, 0,  0, 0, 1);
        add(0, 0, CMD_NOP, 0,  0,  RESP_NONE, 0,  0,   1,  CMD_NOP, 0,  0, 0, RESP_NONE, 0,  0, 0, 0);

        repeat (2) @(posedge clk);
        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst;
            v     = vecs[i].v;
            cmd   = vecs[i].cmd;
            op1   = vecs[i].op1;
            op2   = vecs[i].op2;
            dr    = vecs[i].dr;
            dd    = vecs[i].dd;
            dt    = vecs[i].dt;
            #1;
            check_vec(i, vecs[i]);
        end

        // Lone timeout with TIMEOUT=8: command at cycle 1, response at 10.
        @(negedge clk);
        v8 = 1; cmd8 = CMD_ADD; op1_8 = 1; op2_8 = 2;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            v8 = 0;
            #1;
            if (k == 1) begin
                chk("to1_cmd", 32'(rc8), 32'(CMD_ADD));
                chk("to1_tag", 32'(rt8), 0);
            end
            if (k == 9) begin
                chk("to1_early_valid", 32'(hv8), 0);
                chk("to1_busy", 32'(outst8), 1);
            end
            if (k == 10) begin
                chk("to1_valid", 32'(hv8), 1);
                chk("to1_resp", 32'(hr8), 32'(RESP_TIMEOUT));
                chk("to1_data", hd8, 0);
                chk("to1_tag_rsp", 32'(ht8), 0);
                chk("to1_freed", 32'(outst8), 0);
            end
            if (k == 11) chk("to1_pulse_end", 32'(hv8), 0);
        end

        // Real response on tag 1 coincides with tag 0 timing out.
        @(negedge clk);
        v8 = 1; cmd8 = CMD_ADD; op1_8 = 3; op2_8 = 4;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            v8    = (k == 2);
            cmd8  = CMD_SUB;
            op1_8 = 5;
            op2_8 = 6;
            dr8   = (k == 9) ? RESP_OK : RESP_NONE;
            dd8   = 50;
            dt8   = 1;
            #1;
            if (k == 2) chk("to2_ready_opnd", 32'(rdy8), 1);
            if (k == 3) chk("to2_tag1_issue", 32'(rt8), 1);
            if (k == 10) begin
                chk("to2_real_valid", 32'(hv8), 1);
                chk("to2_real_resp", 32'(hr8), 32'(RESP_OK));
                chk("to2_real_data", hd8, 50);
                chk("to2_real_tag", 32'(ht8), 1);
            end
            if (k == 11) begin
                chk("to2_to_valid", 32'(hv8), 1);
                chk("to2_to_resp", 32'(hr8), 32'(RESP_TIMEOUT));
                chk("to2_to_data", hd8, 0);
                chk("to2_to_tag", 32'(ht8), 0);
                chk("to2_out", 32'(outst8), 0);
            end
            if (k == 12) chk("to2_idle", 32'(hv8), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/calc2_port_issuer.md
Name: calc2_port_issuer

Overview:
- Per-port request issuer that sits directly upstream of one calc2 request port.
- Accepts whole operations (cmd, op1, op2) from a host over a valid/ready handshake.
- Allocates a free 2-bit tag and drives the two-cycle calc2 request sequence.
- Tracks outstanding tags, consumes the matching calc2 response port, and returns tagged responses to the host with per-tag timeout detection. One instance per port; four per calc2.

Parameters:
- TIMEOUT, 64, cycles after the command cycle without a response before a tag is declared timed out. Legal range 2..1023.
- CNT_W, $clog2(TIMEOUT+1), age counter width. Derived; do not override.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- host_req_valid  in  1  host operation valid
- host_req_ready  out  1  issuer can accept an operation this cycle
- host_req_cmd  in  [0:3]  calc2 command
- host_req_op1  in  [0:31]  operand 1
- host_req_op2  in  [0:31]  operand 2
- req_cmd_out  out  [0:3]  to calc2 reqN_cmd_in
- req_data_out  out  [0:31]  to calc2 reqN_data_in
- req_tag_out  out  [0:1]  to calc2 reqN_tag_in
- dut_resp_in  in  [0:1]  from calc2 out_respN
- dut_data_in  in  [0:31]  from calc2 out_dataN
- dut_tag_in  in  [0:1]  from calc2 out_tagN
- host_rsp_valid  out  1  response pulse to host (no backpressure)
- host_rsp_resp  out  [0:1]  1=ok, 2=error, 3=timeout
- host_rsp_data  out  [0:31]  result data; 0 on timeout
- host_rsp_tag  out  [0:1]  tag of completed operation
- outstanding  out  [0:2]  number of busy tags, 0..4
- stray_resp_err  out  1  one-cycle pulse: response on a non-busy tag

Behaviour:
- Bit order: index 0 is the MSB on all vectors.
- Reset (sync, active-high):
  - All outputs go to 0 and the FSM goes to IDLE.
  - All tags are freed and all age counters cleared.
  - Operations in flight are dropped silently; no host_rsp is produced for them.
  - A dut response sampled in the reset cycle is ignored.
- FSM states: IDLE, CMD, OPND.
- host_req_ready = (state IDLE or OPND) and at least one tag free and not reset. It is combinational from registered state only.
- Accept = host_req_valid and host_req_ready.
  - cmd==0: the operation is consumed and discarded; no tag allocated; state unchanged.
  - cmd!=0: latch cmd, op1 and op2. Allocate the lowest-numbered free tag and mark it busy in the same cycle. Go to CMD.
- CMD (one cycle): drive req_cmd_out=cmd, req_data_out=op1, req_tag_out=tag. Clear that tag's age counter. Go to OPND.
- OPND (one cycle): drive req_cmd_out=0, req_data_out=op2, req_tag_out=0.
  - On accept, go to CMD (back-to-back issue, one operation per 2 cycles).
  - Otherwise go to IDLE.
- IDLE: all req_* outputs are 0.
- Latency: accept at cycle T -> command at T+1 -> operand 2 at T+2.
- Response handling: dut_resp_in!=0 at cycle T.
  - Tag busy: free the tag at T. At T+1 drive host_rsp_valid=1 with resp, data and tag registered.
  - Tag not busy: stray_resp_err=1 at T+1; no host_rsp; bitmap unchanged.
- A tag freed at T may be allocated by an accept at T+1 or later, never in the same cycle.
- Age counters:
  - Increment each cycle while the tag is busy and past its CMD cycle.
  - Saturate at TIMEOUT.
  - At TIMEOUT the tag is timed out: free it, emit host_rsp resp=3, data=0, tag.
- Simultaneous events:
  - A real response has priority for the host_rsp slot. A pending timeout waits with its counter held at TIMEOUT and is emitted the next free cycle.
  - Multiple simultaneous timeouts are emitted lowest tag first, one per cycle.
  - A real response arriving for a tag whose timeout is pending but not yet emitted is treated as the real response; the timeout is cancelled.
- outstanding is the registered popcount of the busy bitmap; it updates the cycle after allocate/free.
- All 4 tags busy: host_req_ready=0 until a free occurs.

Decomposition:
- calc2_pkg holds:
  - cmd constants: CMD_NOP=0, ADD=1, SUB=2, SHL=5, SHR=6
  - resp constants: RESP_NONE=0, OK=1, ERR=2, TIMEOUT=3
  - tag_t (2 bits), data_t (32 bits)
- Sub-module calc2_tag_tracker: busy bitmap, lowest-free allocator, per-tag age counters, timeout arbitration, popcount. The issuer keeps the FSM and output registers.

Test Plan:
- Single ADD op1=5 op2=7, accepted at T:
  - T+1: cmd=1, data=5, tag=0.
  - T+2: cmd=0, data=7.
  - DUT resp=1, data=12, tag=0 at T+6 -> host_rsp at T+7 (1, 12, 0); outstanding returns to 0.
- Five back-to-back ops, no responses:
  - Tags 0,1,2,3 are issued every 2 cycles.
  - host_req_ready drops with outstanding=4.
  - Response on tag 2 -> next op gets tag 2.
- Out-of-order responses for tags 3,0 in consecutive cycles -> host_rsp in the same order with tags 3,0; bitmap correct.
- Response with tag 1 while only tag 0 is busy -> stray_resp_err pulse; no host_rsp; outstanding unchanged.
- TIMEOUT=8, no response:
  - host_rsp resp=3, data=0, tag=0 exactly 9 cycles after the CMD cycle; tag freed.
  - A coincident real response on tag 1 is emitted first and the timeout follows one cycle later.
- reset asserted in OPND with 2 tags busy -> next cycle all outputs 0, outstanding=0, ready=1. A later response on an old tag -> stray_resp_err.
